// File: rtl/tqv_periph_bus_initiator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tqv_periph_bus_initiator : single-access TinyQV peripheral bus master
// Revision: 1.0
// ---------------------------------------------------------------------------
module tqv_periph_bus_initiator #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [5:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [5:0]  bus_address,
  output logic [31:0] bus_wdata,
  output logic [1:0]  bus_write_n,
  output logic [1:0]  bus_read_n,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GAP    = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  size_q, size_d;
  logic        write_q, write_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  read_n_q, read_n_d;
  logic [1:0]  write_n_q, write_n_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata_masked;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      size_q      <= 2'b00;
      write_q     <= 1'b0;
      addr_q      <= 6'd0;
      wdata_q     <= 32'd0;
      read_n_q    <= 2'b11;
      write_n_q   <= 2'b11;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      read_n_q    <= read_n_d;
      write_n_q   <= write_n_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    case (size_q)
      2'b00:   rdata_masked = {24'd0, bus_rdata[7:0]};
      2'b01:   rdata_masked = {16'd0, bus_rdata[15:0]};
      default: rdata_masked = bus_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    read_n_d    = read_n_q;
    write_n_d   = write_n_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          size_d  = req_size;
          write_d = req_write;
          if (req_size == 2'b11) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            err_d       = 1'b1;
            rdata_d     = 32'd0;
          end else begin
            // Strobes are loaded here so they are high from the first ACCESS cycle.
            state_d = ACCESS;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            cnt_d   = 8'd0;
            if (req_write) write_n_d = req_size;
            else           read_n_d  = req_size;
          end
        end
      end
      ACCESS: begin
        if (bus_ready) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          err_d       = 1'b0;
          rdata_d     = write_q ? 32'd0 : rdata_masked;
          read_n_d    = 2'b11;
          write_n_d   = 2'b11;
        end else if (cnt_q == TMO_LAST) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          err_d       = 1'b1;
          rdata_d     = 32'd0;
          read_n_d    = 2'b11;
          write_n_d   = 2'b11;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = GAP;
          rsp_valid_d = 1'b0;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready   = rst_n & (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_error   = err_q;
  assign bus_address = addr_q;
  assign bus_wdata   = wdata_q;
  assign bus_write_n = write_n_q;
  assign bus_read_n  = read_n_q;

endmodule
`default_nettype wire

// File: tb/tb_tqv_periph_bus_initiator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tqv_periph_bus_initiator : randomized bench with a PRNG responder model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_tqv_periph_bus_initiator;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [1:0]  req_size;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;
  logic [5:0]  bus_address;
  logic [31:0] bus_wdata, bus_rdata;
  logic [1:0]  bus_write_n, bus_read_n;
  logic        bus_ready;

  always #5 clk = ~clk;

  tqv_periph_bus_initiator #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .bus_address(bus_address), .bus_wdata(bus_wdata),
    .bus_write_n(bus_write_n), .bus_read_n(bus_read_n),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] xs(input logic [31:0] x);
    x = x ^ (x << 13);
    x = x ^ (x >> 17);
    x = x ^ (x << 5);
    return x;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder + bus monitor state
  int          resp_delay   = 0;
  bit          fixed_mode   = 1'b1;
  logic [31:0] prng         = 32'h1;
  int          adv_cnt      = 0;
  bit          adv_pending  = 1'b0;
  int          act_cnt      = 0;
  int          strobe_total = 0;
  int          idle_run     = 0;
  bit          seen_access  = 1'b0;
  bit          exp_write    = 1'b0;
  logic [1:0]  exp_size     = 2'b00;
  logic [5:0]  exp_addr     = 6'd0;
  logic [31:0] exp_wdata    = 32'd0;

  // Reference model state
  logic [31:0] model_prng  = 32'h1;
  int          model_reads = 0;

  always @(negedge clk) begin : responder
    bit rd_act, wr_act;
    if (adv_pending) begin
      prng = xs(prng);
      adv_cnt++;
      adv_pending = 1'b0;
    end
    rd_act = (bus_read_n != 2'b11);
    wr_act = (bus_write_n != 2'b11);
    if (rd_act || wr_act) begin
      if (seen_access && act_cnt == 0) check_eq("gap_idle", 32'(idle_run >= 2), 32'd1);
      seen_access = 1'b1;
      idle_run    = 0;
      check_eq("strobe_val", 32'(wr_act ? bus_write_n : bus_read_n), 32'(exp_size));
      check_eq("other_strobe", 32'(wr_act ? bus_read_n : bus_write_n), 32'd3);
      check_eq("strobe_dir", 32'(wr_act), 32'(exp_write));
      check_eq("bus_addr", 32'(bus_address), 32'(exp_addr));
      if (wr_act) check_eq("bus_wdata", bus_wdata, exp_wdata);
      bus_ready = (act_cnt >= resp_delay);
      if (bus_ready && rd_act && !fixed_mode) adv_pending = 1'b1;
      act_cnt++;
      strobe_total++;
    end else begin
      act_cnt   = 0;
      idle_run++;
      bus_ready = 1'($urandom_range(0, 1));
    end
    bus_rdata = fixed_mode ? 32'h89ABCDEF : prng;
  end

  task automatic do_acc(input bit wr, input logic [1:0] sz, input logic [5:0] ad,
                        input logic [31:0] wd, input int dly, input int hold,
                        output int acc_cyc);
    int n, st0, exp_st, exp_lat;
    logic [31:0] exp_rd, v;
    bit exp_er;
    exp_er  = (sz == 2'b11) || (dly >= T);
    exp_st  = (sz == 2'b11) ? 0 : ((dly < T) ? dly + 1 : T);
    exp_lat = (sz == 2'b11) ? 1 : ((dly < T) ? dly + 2 : T + 1);
    exp_rd  = 32'd0;
    if (!exp_er && !wr) begin
      v = fixed_mode ? 32'h89ABCDEF : model_prng;
      if (!fixed_mode) begin
        model_prng = xs(model_prng);
        model_reads++;
      end
      exp_rd = (sz == 2'b00) ? (v & 32'h0000_00FF) :
               (sz == 2'b01) ? (v & 32'h0000_FFFF) : v;
    end
    resp_delay = dly;
    exp_write  = wr;
    exp_size   = sz;
    exp_addr   = ad;
    exp_wdata  = wd;

    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check_eq("req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_addr = ad; req_wdata = wd;
    acc_cyc = cyc;
    st0     = strobe_total;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_size  = 2'($urandom);
    req_addr  = 6'($urandom);
    req_wdata = $urandom;

    @(negedge clk);
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("latency", 32'(cyc - acc_cyc), 32'(exp_lat));
    check_eq("rsp_rdata", rsp_rdata, exp_rd);
    check_eq("rsp_error", 32'(rsp_error), 32'(exp_er));
    check_eq("strobe_cycles", 32'(strobe_total - st0), 32'(exp_st));
    repeat (hold) begin
      @(negedge clk);
      check_eq("hold_valid", 32'(rsp_valid), 32'd1);
      check_eq("hold_rdata", rsp_rdata, exp_rd);
      check_eq("hold_error", 32'(rsp_error), 32'(exp_er));
      check_eq("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a[4], adv0, n;
    bit wr;
    logic [1:0] sz;
    int dly;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_addr = 6'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    bus_ready = 1'b0; bus_rdata = 32'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rst_rsp_error", 32'(rsp_error), 32'd0);
    check_eq("rst_write_n", 32'(bus_write_n), 32'd3);
    check_eq("rst_read_n", 32'(bus_read_n), 32'd3);
    check_eq("rst_addr", 32'(bus_address), 32'd0);
    check_eq("rst_wdata", bus_wdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rel_req_ready", 32'(req_ready), 32'd1);

    // Fixed-pattern reads of every legal size
    fixed_mode = 1'b1;
    do_acc(1'b0, 2'b10, 6'h00, 32'h0, 0, 0, a0);
    do_acc(1'b0, 2'b00, 6'h00, 32'h0, 0, 0, a0);
    do_acc(1'b0, 2'b01, 6'h00, 32'h0, 0, 0, a0);

    // PRNG responder: seed write, then back-to-back reads
    fixed_mode = 1'b0;
    do_acc(1'b1, 2'b10, 6'h01, 32'h12345678, 0, 0, a0);
    adv0 = adv_cnt;
    for (int i = 0; i < 4; i++) do_acc(1'b0, 2'b10, 6'h02, 32'h0, 0, 0, a[i]);
    @(negedge clk);
    for (int i = 1; i < 4; i++) check_eq("b2b_period", 32'(a[i] - a[i-1]), 32'd4);
    check_eq("b2b_advances", 32'(adv_cnt - adv0), 32'd4);

    // Delayed ready, timeout, illegal size, stalled response
    do_acc(1'b0, 2'b10, 6'h03, 32'h0, 3, 0, a0);
    do_acc(1'b0, 2'b10, 6'h04, 32'h0, 40, 0, a0);
    do_acc(1'b0, 2'b11, 6'h05, 32'h0, 0, 0, a0);
    do_acc(1'b1, 2'b11, 6'h06, 32'hDEADBEEF, 0, 0, a0);
    do_acc(1'b0, 2'b01, 6'h07, 32'h0, 1, 5, a0);

    // Reset in the middle of an access
    resp_delay = 10; exp_write = 1'b0; exp_size = 2'b10; exp_addr = 6'h09;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 6'h09;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("mid_strobe_active", 32'(bus_read_n), 32'd2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("mrst_read_n", 32'(bus_read_n), 32'd3);
    check_eq("mrst_write_n", 32'(bus_write_n), 32'd3);
    check_eq("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("mrst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mrst_rel_ready", 32'(req_ready), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      wr  = 1'($urandom);
      sz  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      dly = ($urandom_range(0, 7) == 0) ? T + 2 : int'($urandom_range(0, 3));
      do_acc(wr, sz, 6'($urandom), $urandom, dly, int'($urandom_range(0, 3)), a1);
    end

    repeat (3) @(negedge clk);
    check_eq("total_advances", 32'(adv_cnt), 32'(model_reads));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/tqv_periph_bus_initiator.md
Name: tqv_periph_bus_initiator

Overview:
- Bus master for the TinyQV peripheral interface. It drives address, write data and the read/write strobes into a peripheral, and it samples that peripheral's data_out and data_ready.
- Upstream logic issues single accesses through a valid/ready request channel and receives results on a valid/ready response channel.
- Used to seed and drain peripherals such as the xoshiro PRNG from on-chip sequencers and test harnesses without the CPU.
- Includes a timeout and guaranteed idle gaps between accesses, so read-triggered side effects in the responder fire exactly once per access.

Parameters:
TIMEOUT_CYCLES, 16, max strobe-asserted cycles without bus_ready before the access is aborted (legal range 1..255)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid & req_ready at rising edge
req_write  in  1  1 = write, 0 = read
req_size  in  2  00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = illegal
req_addr  in  6  peripheral register address
req_wdata  in  32  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready at rising edge
rsp_rdata  out  32  read data, zero-extended per size; 0 for writes and errors
rsp_error  out  1  1 = timeout or illegal size
bus_address  out  6  to peripheral address
bus_wdata  out  32  to peripheral data_in
bus_write_n  out  2  to peripheral data_write_n
bus_read_n  out  2  to peripheral data_read_n
bus_rdata  in  32  from peripheral data_out
bus_ready  in  1  from peripheral data_ready

Behaviour:
- Reset values:
  - req_ready = 0 during reset, 1 in the first cycle after reset release.
  - rsp_valid = 0, rsp_rdata = 0, rsp_error = 0.
  - bus_write_n = bus_read_n = 2'b11, bus_address = 0, bus_wdata = 0.
- FSM states: IDLE, GAP, ACCESS, RESP. Reset enters IDLE.
- IDLE:
  - req_ready = 1.
  - On handshake, latch addr, wdata, size and write.
  - Legal size: go to ACCESS.
  - size 11: go directly to RESP with rsp_error = 1 and rsp_rdata = 0. No bus strobe is issued.
- ACCESS:
  - Drive bus_address and bus_wdata from the latched values.
  - Drive the selected strobe = size; the other strobe = 11.
  - The timeout counter starts at 0 on entry and increments each ACCESS cycle.
  - In any ACCESS cycle with bus_ready = 1:
    - Complete the access.
    - For reads, capture bus_rdata masked to size: byte gives {24'b0, [7:0]}; half gives {16'b0, [15:0]}; word gives the full 32 bits.
    - For writes, rsp_rdata = 0.
    - rsp_error = 0. Go to RESP.
  - If the counter reaches TIMEOUT_CYCLES - 1 with bus_ready = 0: go to RESP, rsp_error = 1, rsp_rdata = 0.
- RESP:
  - Strobes = 11. rsp_valid = 1. Response fields stay stable until handshake.
  - On rsp_ready, go to GAP.
- GAP:
  - Exactly one cycle. Strobes = 11, req_ready = 0. Then go to IDLE.
  - Guarantees at least 2 strobe-idle cycles (RESP + GAP) between any two accesses.
- Strobes are registered outputs and are asserted only in ACCESS. bus_address and bus_wdata hold their last values outside ACCESS.
- Latency with a ready-always responder:
  - Accept at edge 0; strobe high during cycle 1; rsp_valid in cycle 2.
  - With rsp_ready held high: req_ready again in cycle 4, so the back-to-back period is 4 cycles.
- Only one access is outstanding at a time. req_* is ignored outside IDLE.
- A synchronous reset mid-access forces IDLE with strobes 11 at the next edge. The pending response is discarded.
- bus_ready sampled outside ACCESS is ignored.

Test Plan:
- 32-bit read, addr 0x00, responder ready = 1 returning 0x89ABCDEF -> bus_read_n = 10 for exactly 1 cycle, rsp_valid 2 cycles after accept, rsp_rdata = 0x89ABCDEF, rsp_error = 0.
- 8-bit and 16-bit reads of 0x89ABCDEF -> rsp_rdata = 0x000000EF and 0x0000CDEF; strobe values 00 and 01.
- 32-bit write 0x12345678 to addr 0x01, then reads from a PRNG model with a read-triggered advance -> bus_write_n = 10 for 1 cycle with bus_wdata correct. Four back-to-back reads advance the model exactly 4 times, and strobes are 11 for ≥2 cycles between accesses.
- Responder delays bus_ready by 3 cycles -> strobe held 4 cycles, correct data. Responder never ready with TIMEOUT_CYCLES = 16 -> strobe held 16 cycles, then rsp_error = 1, rsp_rdata = 0.
- req_size = 11 -> no strobe ever leaves 11; response with rsp_error = 1 one cycle after accept.
- rsp_ready held 0 for 5 cycles -> response stable and req_ready = 0 throughout. rst_n pulsed low mid-ACCESS -> strobes = 11 next edge, rsp_valid = 0, req_ready = 1 after release.
